issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
Parametrised successor to the fixed two-cycle scoreboard used by the issue stage. It tracks a pending-write state for every architectural register. Fixed-latency writes clear themselves through a per-register down-counter; variable-latency writes (mul/div, loads) clear on any of NUM_WB write-back ports. It generates stall for RAW/WAW hazards, a programmable-length kill window after a taken branch/jump, and an issue_fire qualifier consumed by the issue-stage pipe register.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero.
AW, 5, register address width, equal to clog2(NREG).
LAT_W, 3, latency field width; maximum fixed latency is 2**LAT_W-1.
NUM_WB, 2, number of variable-latency write-back release ports.
KILL_CYCLES, 2, number of cycles kill stays asserted per taken branch; must be at least 1.
CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
issue_valid  in  1  decoded instruction present at issue
rs1, rs2  in  AW each  source register addresses
rs1_used, rs2_used  in  1 each  corresponding source is actually read
rd  in  AW  destination register address
rd_we  in  1  instruction writes rd
lat  in  LAT_W  fixed write latency in cycles; 0 means variable latency
btaken  in  1  taken branch/jump resolved in execute
wb_valid  in  NUM_WB  variable-latency write-back strobes
wb_rd  in  NUM_WB*AW  write-back addresses, port k at bits [k*AW +: AW]
stall  out  1  hold fetch/decode; inject bubble
kill  out  1  squash the instruction at issue
issue_fire  out  1  instruction accepted this cycle
busy  out  NREG  pending-write vector
stall_cycles  out  CNT_W  consecutive stall cycles, saturating

Behaviour:
- Reset (nrst low, asynchronous):
  - all busy, var, cnt and kill_cnt are 0; stall_cycles is 0.
  - stall is 0; kill follows btaken only.
- Per-register state: busy, var, cnt[LAT_W]. Register 0 is never busy; writes to it are ignored.
- Hazard (combinational):
  - raw = (rs1_used & rs1!=0 & busy[rs1]) | (rs2_used & rs2!=0 & busy[rs2]).
  - waw = rd_we & rd!=0 & busy[rd].
- kill = btaken | (kill_cnt != 0).
- stall = issue_valid & (raw | waw) & !kill. Kill has priority; stall is never high in a killed cycle.
- issue_fire = issue_valid & !stall & !kill.
- Allocation, on the clock edge where issue_fire & rd_we & rd!=0:
  - busy[rd] is set to 1.
  - If lat!=0: cnt set to lat, var set to 0.
  - If lat==0: var set to 1, cnt set to 0.
- Fixed release: on each edge where busy & !var, cnt decrements; busy clears on the edge where cnt goes 1->0. A latency-L write is therefore visible as busy for exactly L cycles after the fire cycle.
- Variable release: on an edge where wb_valid[k] & wb_rd[k]==r & busy[r] & var[r], busy and var clear.
  - Write-backs to non-busy or fixed entries are ignored.
  - Multiple ports hitting the same register is legal (idempotent).
- No same-cycle bypass: a release and a dependent issue in the same cycle still stalls. The consumer fires the following cycle.
- Allocation and release can never target the same register on one edge, because WAW stalls any new writer while the register is busy.
- Kill window:
  - btaken loads kill_cnt with KILL_CYCLES-1.
  - Otherwise a non-zero kill_cnt decrements.
  - btaken during an active window reloads it.
  - Killed instructions never allocate.
- stall_cycles: increments while stall is high, saturating at all-ones; clears on any cycle where stall is low.
- Reset mid-operation drops all pending state immediately; in-flight write-backs arriving after reset are ignored.

Decomposition:
- Package issue_pkg holds the NREG/AW/LAT_W defaults, the typedef lat_t (logic [LAT_W-1:0]), and the typedef sb_entry_t {busy, var, cnt}.
- Sub-module sb_entry holds one register's busy/var/cnt with alloc, lat, and release inputs. It is instantiated with generate for registers 1..NREG-1; index 0 is tied to not-busy.

Test Plan:
1. Reset, then fire rd=5 lat=3 in cycle 0; in cycle 1 present rs1=5 rs1_used=1 -> stall=1 in cycles 1-3, issue_fire=1 in cycle 4, stall_cycles reads 3 in cycle 3 then 0.
2. Fire rd=7 lat=0 in cycle 0; consumer rs2=7 waits; wb_valid=2'b10 with wb_rd[1]=7 in cycle 10 -> stall through cycle 10, fire in cycle 11, busy[7]=0 from cycle 11.
3. Fire rd=0 lat=3, then rs1=0 consumer -> busy stays 0, no stall; rs2=3 with rs2_used=0 while busy[3]=1 -> no stall.
4. WAW: rd=3 variable-latency busy, new writer rd=3 lat=1 -> stall until wb clears 3; then the new entry is busy for 1 cycle.
5. KILL_CYCLES=2, btaken in cycle 4 while a RAW stall is active -> kill=1 in cycles 4-5, stall=0, issue_fire=0, rd=9 instruction in cycle 5 leaves busy[9]=0; btaken again in cycle 5 extends kill to cycle 6.
6. Assert nrst low with registers 5 and 7 busy -> busy=0 asynchronously; a later wb_rd=7 strobe has no effect.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared widths and per-register scoreboard types for the issue stage.
// The lat_t width here sets the latency width used by every sb_entry.
package issue_pkg;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int LAT_W = 3;

  typedef logic [LAT_W-1:0] lat_t;

  // "var" is a SystemVerilog keyword, hence is_var for the variable-latency flag.
  typedef struct packed {
    logic busy;
    logic is_var;
    lat_t cnt;
  } sb_entry_t;

endpackage

// File: rtl/sb_entry.sv
// Pending-write state for one architectural register: fixed writes count
// themselves down, variable writes wait for a matching write-back.
module sb_entry
  import issue_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic alloc,
  input  lat_t lat,
  input  logic rel,
  output logic busy
);

  sb_entry_t ent;

  // Allocation never coincides with a release: a busy register stalls any new writer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ent <= '0;
    end else if (alloc) begin
      ent.busy   <= 1'b1;
      ent.is_var <= (lat == '0);
      ent.cnt    <= lat;
    end else if (ent.busy && !ent.is_var) begin
      ent.cnt <= ent.cnt - 1'b1;
      if (ent.cnt == lat_t'(1)) ent.busy <= 1'b0;
    end else if (ent.busy && ent.is_var && rel) begin
      ent <= '0;
    end
  end

  assign busy = ent.busy;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage scoreboard: RAW/WAW stall, post-branch kill window and issue_fire.
// LAT_W must match the lat_t width in issue_pkg.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int NREG        = issue_pkg::NREG,
  parameter int AW          = issue_pkg::AW,
  parameter int LAT_W       = issue_pkg::LAT_W,
  parameter int NUM_WB      = 2,
  parameter int KILL_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [AW-1:0]        rd,
  input  logic                 rd_we,
  input  logic [LAT_W-1:0]     lat,
  input  logic                 btaken,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [NUM_WB*AW-1:0] wb_rd,
  output logic                 stall,
  output logic                 kill,
  output logic                 issue_fire,
  output logic [NREG-1:0]      busy,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int KW = $clog2(KILL_CYCLES) + 1;

  logic          raw;
  logic          waw;
  logic [KW-1:0] kill_cnt;
  logic [CNT_W-1:0] stall_run;

  always_comb begin
    raw = (rs1_used && rs1 != '0 && busy[rs1]) ||
          (rs2_used && rs2 != '0 && busy[rs2]);
    waw = rd_we && rd != '0 && busy[rd];
  end

  assign kill       = btaken || (kill_cnt != '0);
  assign stall      = issue_valid && (raw || waw) && !kill;
  assign issue_fire = issue_valid && !stall && !kill;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      kill_cnt <= '0;
    end else if (btaken) begin
      kill_cnt <= KW'(KILL_CYCLES - 1);
    end else if (kill_cnt != '0) begin
      kill_cnt <= kill_cnt - 1'b1;
    end
  end

  // stall_cycles includes the current stall cycle, so it drops to 0 the cycle stall does.
  always_comb begin
    if (!stall) begin
      stall_cycles = '0;
    end else if (&stall_run) begin
      stall_cycles = stall_run;
    end else begin
      stall_cycles = stall_run + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_run <= '0;
    end else begin
      stall_run <= stall_cycles;
    end
  end

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic hit;
    logic alloc;

    always_comb begin
      hit = 1'b0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && wb_rd[k*AW +: AW] == AW'(r)) hit = 1'b1;
      end
    end

    assign alloc = issue_fire && rd_we && (rd == AW'(r));

    sb_entry u_entry (
      .clk   (clk),
      .nrst  (nrst),
      .alloc (alloc),
      .lat   (lat_t'(lat)),
      .rel   (hit),
      .busy  (busy[r])
    );
  end

endmodule
